// File: rtl/sc_frog_ctrl.sv
// Frog game-state controller: button edge detect, frog position, lives, score, win/over FSM, LED row bytes.
// Latency: position/state update 1 clock after a press edge; row bytes follow 1 clock after that.
// Backpressure: none; buttons are debounced levels sampled every clock, collision is a level input.
// Ports: CLOCK_50/RESET_InLow (async, active-low); five button levels and collision in;
//        data0..data7 row bytes (data0 = start row, data7 = goal row), posX, posY, lives, score, state out.
module sc_frog_ctrl #(
  parameter int DATAWIDTH_BUS       = 8,
  parameter int PRESCALER_DATAWIDTH = 25,
  parameter int HOLD_CYCLES         = 25000000,
  parameter int BLINK_CYCLES        = 6250000,
  parameter int LIVES_INIT          = 3,
  parameter int START_X             = 3
) (
  input  logic                             SC_FROGCTRL_CLOCK_50,
  input  logic                             SC_FROGCTRL_RESET_InLow,
  input  logic                             SC_FROGCTRL_startButton_In,
  input  logic                             SC_FROGCTRL_upButton_In,
  input  logic                             SC_FROGCTRL_downButton_In,
  input  logic                             SC_FROGCTRL_leftButton_In,
  input  logic                             SC_FROGCTRL_rightButton_In,
  input  logic                             SC_FROGCTRL_collision_In,
  output logic [DATAWIDTH_BUS-1:0]         SC_FROGCTRL_data0_Out,
  output logic [DATAWIDTH_BUS-1:0]         SC_FROGCTRL_data1_Out,
  output logic [DATAWIDTH_BUS-1:0]         SC_FROGCTRL_data2_Out,
  output logic [DATAWIDTH_BUS-1:0]         SC_FROGCTRL_data3_Out,
  output logic [DATAWIDTH_BUS-1:0]         SC_FROGCTRL_data4_Out,
  output logic [DATAWIDTH_BUS-1:0]         SC_FROGCTRL_data5_Out,
  output logic [DATAWIDTH_BUS-1:0]         SC_FROGCTRL_data6_Out,
  output logic [DATAWIDTH_BUS-1:0]         SC_FROGCTRL_data7_Out,
  output logic [$clog2(DATAWIDTH_BUS)-1:0] SC_FROGCTRL_posX_Out,
  output logic [2:0]                       SC_FROGCTRL_posY_Out,
  output logic [2:0]                       SC_FROGCTRL_lives_Out,
  output logic [7:0]                       SC_FROGCTRL_score_Out,
  output logic [2:0]                       SC_FROGCTRL_state_Out
);

  localparam int XW = $clog2(DATAWIDTH_BUS);
  localparam int PW = PRESCALER_DATAWIDTH;
  localparam logic [XW-1:0] SPAWN_X    = XW'(START_X);
  localparam logic [XW-1:0] X_MAX      = XW'(DATAWIDTH_BUS - 1);
  localparam logic [2:0]    LIVES_LOAD = 3'(LIVES_INIT);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] BLINK_LAST = PW'(BLINK_CYCLES - 1);
  localparam logic [DATAWIDTH_BUS-1:0] ONE = {{(DATAWIDTH_BUS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  // Button vector order: [4]=start [3]=up [2]=down [1]=left [0]=right
  logic [4:0]  w_btn, w_press, r_prev;
  state_t      r_state, w_state_nxt;
  logic [XW-1:0] r_posx, w_posx_nxt;
  logic [2:0]  r_posy, w_posy_nxt;
  logic [2:0]  r_lives, w_lives_nxt;
  logic [7:0]  r_score, w_score_nxt;
  logic [PW-1:0] r_cnt, w_cnt_nxt;
  logic [PW-1:0] r_bcnt, w_bcnt_nxt;
  logic        r_blink, w_blink_nxt;
  logic        w_vis;
  logic [DATAWIDTH_BUS-1:0] w_onehot;
  logic [DATAWIDTH_BUS-1:0] w_row [0:7];
  logic [DATAWIDTH_BUS-1:0] r_data [0:7];

  assign w_btn   = {SC_FROGCTRL_startButton_In, SC_FROGCTRL_upButton_In,
                    SC_FROGCTRL_downButton_In, SC_FROGCTRL_leftButton_In,
                    SC_FROGCTRL_rightButton_In};
  assign w_press = w_btn & ~r_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_posx_nxt  = r_posx;
    w_posy_nxt  = r_posy;
    w_lives_nxt = r_lives;
    w_score_nxt = r_score;
    w_cnt_nxt   = r_cnt;
    w_bcnt_nxt  = r_bcnt;
    w_blink_nxt = r_blink;
    case (r_state)
      ST_IDLE: begin
        if (w_press[4]) begin
          w_state_nxt = ST_PLAY;
          w_lives_nxt = LIVES_LOAD;
          w_posx_nxt  = SPAWN_X;
          w_posy_nxt  = 3'd0;
          w_score_nxt = 8'd0;
        end
      end
      ST_PLAY: begin
        // Collision wins over both the goal check and any same-cycle move.
        if (SC_FROGCTRL_collision_In) begin
          w_state_nxt = ST_HIT;
          w_lives_nxt = r_lives - 3'd1;
          w_cnt_nxt   = '0;
          w_bcnt_nxt  = '0;
          w_blink_nxt = 1'b0;
        end else if (r_posy == 3'd7) begin
          w_state_nxt = ST_WIN;
          w_score_nxt = r_score + 8'd1;
          w_cnt_nxt   = '0;
        end else if (w_press[3]) begin
          if (r_posy != 3'd7) w_posy_nxt = r_posy + 3'd1;
        end else if (w_press[2]) begin
          if (r_posy != 3'd0) w_posy_nxt = r_posy - 3'd1;
        end else if (w_press[1]) begin
          if (r_posx != X_MAX) w_posx_nxt = r_posx + XW'(1);
        end else if (w_press[0]) begin
          if (r_posx != '0) w_posx_nxt = r_posx - XW'(1);
        end
      end
      ST_HIT: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt = '0;
          if (r_lives == 3'd0) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt = ST_PLAY;
            w_posx_nxt  = SPAWN_X;
            w_posy_nxt  = 3'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + PW'(1);
          // r_blink tracks (r_cnt / BLINK_CYCLES) odd, i.e. frog shown on odd half-periods.
          if (r_bcnt == BLINK_LAST) begin
            w_bcnt_nxt  = '0;
            w_blink_nxt = ~r_blink;
          end else begin
            w_bcnt_nxt = r_bcnt + PW'(1);
          end
        end
      end
      ST_WIN: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_PLAY;
          w_posx_nxt  = SPAWN_X;
          w_posy_nxt  = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + PW'(1);
        end
      end
      ST_OVER: begin
        if (w_press[4]) begin
          w_state_nxt = ST_IDLE;
          w_posx_nxt  = SPAWN_X;
          w_posy_nxt  = 3'd0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Row image from the current registered position; registered below, so rows lag position by one clock.
  always_comb begin
    w_vis    = (r_state == ST_HIT) ? r_blink : (r_state != ST_OVER);
    w_onehot = ONE << r_posx;
    for (int n = 0; n < 8; n++) begin
      w_row[n] = (r_posy == 3'(n) && w_vis) ? w_onehot : '0;
    end
  end

  always_ff @(posedge SC_FROGCTRL_CLOCK_50 or negedge SC_FROGCTRL_RESET_InLow) begin
    if (!SC_FROGCTRL_RESET_InLow) begin
      r_prev  <= '0;
      r_state <= ST_IDLE;
      r_posx  <= SPAWN_X;
      r_posy  <= 3'd0;
      r_lives <= LIVES_LOAD;
      r_score <= 8'd0;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_blink <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        r_data[n] <= (n == 0) ? (ONE << SPAWN_X) : '0;
      end
    end else begin
      r_prev  <= w_btn;
      r_state <= w_state_nxt;
      r_posx  <= w_posx_nxt;
      r_posy  <= w_posy_nxt;
      r_lives <= w_lives_nxt;
      r_score <= w_score_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_blink <= w_blink_nxt;
      for (int n = 0; n < 8; n++) begin
        r_data[n] <= w_row[n];
      end
    end
  end

  assign SC_FROGCTRL_data0_Out = r_data[0];
  assign SC_FROGCTRL_data1_Out = r_data[1];
  assign SC_FROGCTRL_data2_Out = r_data[2];
  assign SC_FROGCTRL_data3_Out = r_data[3];
  assign SC_FROGCTRL_data4_Out = r_data[4];
  assign SC_FROGCTRL_data5_Out = r_data[5];
  assign SC_FROGCTRL_data6_Out = r_data[6];
  assign SC_FROGCTRL_data7_Out = r_data[7];
  assign SC_FROGCTRL_posX_Out  = r_posx;
  assign SC_FROGCTRL_posY_Out  = r_posy;
  assign SC_FROGCTRL_lives_Out = r_lives;
  assign SC_FROGCTRL_score_Out = r_score;
  assign SC_FROGCTRL_state_Out = r_state;

endmodule

// File: tb/tb_sc_frog_ctrl.sv
// Bench for sc_frog_ctrl: directed game scenarios plus random button/collision traffic,
// every cycle compared against a game-rule reference model kept here.
module tb_sc_frog_ctrl;

  localparam int HOLD  = 20;
  localparam int BLINK = 4;
  localparam int LIVES = 3;
  localparam int SX    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;   // [4]=start [3]=up [2]=down [1]=left [0]=right
  logic       col = 1'b0;
  logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [2:0] posx, posy, lives, state;
  logic [7:0] score;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: game rules in plain integers; age = clocks spent in the current state.
  int          m_state, m_x, m_y, m_lives, m_score, m_age;
  logic [4:0]  m_prev;
  logic [63:0] m_rows;

  always #5 clk = ~clk;

  sc_frog_ctrl #(
    .DATAWIDTH_BUS(8), .PRESCALER_DATAWIDTH(25), .HOLD_CYCLES(HOLD),
    .BLINK_CYCLES(BLINK), .LIVES_INIT(LIVES), .START_X(SX)
  ) dut (
    .SC_FROGCTRL_CLOCK_50(clk),
    .SC_FROGCTRL_RESET_InLow(rst_n),
    .SC_FROGCTRL_startButton_In(btn[4]),
    .SC_FROGCTRL_upButton_In(btn[3]),
    .SC_FROGCTRL_downButton_In(btn[2]),
    .SC_FROGCTRL_leftButton_In(btn[1]),
    .SC_FROGCTRL_rightButton_In(btn[0]),
    .SC_FROGCTRL_collision_In(col),
    .SC_FROGCTRL_data0_Out(d0), .SC_FROGCTRL_data1_Out(d1),
    .SC_FROGCTRL_data2_Out(d2), .SC_FROGCTRL_data3_Out(d3),
    .SC_FROGCTRL_data4_Out(d4), .SC_FROGCTRL_data5_Out(d5),
    .SC_FROGCTRL_data6_Out(d6), .SC_FROGCTRL_data7_Out(d7),
    .SC_FROGCTRL_posX_Out(posx),
    .SC_FROGCTRL_posY_Out(posy),
    .SC_FROGCTRL_lives_Out(lives),
    .SC_FROGCTRL_score_Out(score),
    .SC_FROGCTRL_state_Out(state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [63:0] rows_of(int st, int x, int y, int age);
    logic [63:0] r;
    bit vis;
    r = '0;
    if (st == 4)      vis = 1'b0;
    else if (st == 2) vis = ((age / BLINK) % 2) == 1;
    else              vis = 1'b1;
    if (vis) r[y*8 + x] = 1'b1;
    return r;
  endfunction

  task automatic m_reset();
    m_state = 0; m_x = SX; m_y = 0; m_lives = LIVES; m_score = 0; m_age = 0;
    m_prev  = '0;
    m_rows  = rows_of(0, SX, 0, 0);
  endtask

  task automatic m_spawn();
    m_x = SX;
    m_y = 0;
  endtask

  task automatic model_step(input logic [4:0] b, input logic c);
    logic [63:0] nr;
    logic [4:0]  p;
    nr = rows_of(m_state, m_x, m_y, m_age);
    p  = b & ~m_prev;
    m_prev = b;
    case (m_state)
      0: if (p[4]) begin
           m_state = 1; m_lives = LIVES; m_score = 0; m_spawn();
         end
      1: if (c) begin
           m_state = 2; m_lives = m_lives - 1; m_age = 0;
         end else if (m_y == 7) begin
           m_state = 3; m_score = (m_score + 1) % 256; m_age = 0;
         end else if (p[3]) m_y = (m_y < 7) ? m_y + 1 : 7;
         else if (p[2])     m_y = (m_y > 0) ? m_y - 1 : 0;
         else if (p[1])     m_x = (m_x < 7) ? m_x + 1 : 7;
         else if (p[0])     m_x = (m_x > 0) ? m_x - 1 : 0;
      2: if (m_age == HOLD - 1) begin
           m_age = 0;
           if (m_lives == 0) m_state = 4;
           else begin m_state = 1; m_spawn(); end
         end else m_age++;
      3: if (m_age == HOLD - 1) begin
           m_age = 0; m_state = 1; m_spawn();
         end else m_age++;
      4: if (p[4]) begin m_state = 0; m_spawn(); end
      default: ;
    endcase
    m_rows = nr;
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_state"}, state, m_state);
    chk({ph, "_posx"},  posx,  m_x);
    chk({ph, "_posy"},  posy,  m_y);
    chk({ph, "_lives"}, lives, m_lives);
    chk({ph, "_score"}, score, m_score);
    chk({ph, "_rows"},  {d7, d6, d5, d4, d3, d2, d1, d0}, m_rows);
  endtask

  // One clock: drive at negedge, step model, sample 1 ns after the rising edge.
  task automatic cyc(input logic [4:0] b, input logic c, input string ph);
    btn = b;
    col = c;
    model_step(b, c);
    @(posedge clk);
    #1;
    check_all(ph);
    @(negedge clk);
  endtask

  task automatic tap(input logic [4:0] b, input int hold, input string ph);
    for (int i = 0; i < hold; i++) cyc(b, 1'b0, ph);
    cyc(5'b0, 1'b0, ph);
  endtask

  task automatic idle(input int n, input string ph);
    for (int i = 0; i < n; i++) cyc(5'b0, 1'b0, ph);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Start a game, climb three rows with long holds.
    tap(5'b10000, 1, "start");
    for (int k = 0; k < 3; k++) tap(5'b01000, 10, "up3");
    chk("t1_row3", d3, 8'h08);
    chk("t1_posy", posy, 3);

    // Bounds and priority.
    for (int k = 0; k < 4; k++) tap(5'b00001, 1, "right");
    chk("right_sat", posx, 0);
    for (int k = 0; k < 8; k++) tap(5'b00010, 1, "left");
    chk("left_sat", posx, 7);
    tap(5'b01010, 1, "upleft");
    chk("upleft_y", posy, 4);
    tap(5'b00100, 1, "down");
    tap(5'b00100, 1, "down");

    // Collision at row 2, blink through HIT, respawn.
    cyc(5'b01000, 1'b1, "hit");
    chk("hit_lives", lives, 2);
    idle(HOLD + 2, "hitwait");

    // Reach the goal while noise hits WIN.
    for (int k = 0; k < 7; k++) tap(5'b01000, 1, "climb");
    for (int i = 0; i < HOLD + 3; i++)
      cyc(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "winnoise");
    idle(3, "winend");

    // Lose remaining lives.
    for (int k = 0; k < 2; k++) begin
      cyc(5'b0, 1'b1, "lose");
      idle(HOLD + 2, "losewait");
    end
    chk("over_state", state, 4);
    chk("over_rows", {d7, d6, d5, d4, d3, d2, d1, d0}, 64'h0);
    tap(5'b10000, 1, "to_idle");
    tap(5'b10000, 1, "restart");
    chk("restart_lives", lives, 3);

    // 256 crossings wrap the score.
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < 7; k++) tap(5'b01000, 1, "wrap");
      idle(HOLD + 2, "wrapwin");
    end
    chk("score_wrap", score, 0);

    // Asynchronous reset in the middle of HIT.
    tap(5'b01000, 1, "prehit");
    cyc(5'b0, 1'b1, "hit2");
    idle(5, "hit2wait");
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    check_all("async_hold");
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] b;
      b[4] = $urandom_range(0, 99) < 4;
      b[3] = $urandom_range(0, 99) < 35;
      b[2] = $urandom_range(0, 99) < 15;
      b[1] = $urandom_range(0, 99) < 20;
      b[0] = $urandom_range(0, 99) < 20;
      cyc(b, 1'($urandom_range(0, 99) < 2), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
